mopshub_test_sequencer: RTL
===========================

Name: mopshub_test_sequencer

Overview:
Synthesisable, parametrised sequencer that runs the per-bus MOPSHUB bring-up test campaign: RX, then TX, then custom-message phases for every enabled CAN bus. It drives the data generator's test_rx/test_tx/test_advanced levels, generates the endwait_all pulse and the inter-phase gap, and applies a per-phase timeout. It sits between the sign-on logic and the data generator, and accumulates pass/fail statistics for readout.

Parameters:
N_BUSES, 32, number of CAN buses handled (1..32)
BUS_W, 5, width of bus index; must satisfy 2**BUS_W >= N_BUSES
GAP_CYCLES, 120, idle clk_40_m cycles between endwait_all pulse and TX phase start (min 1)
TIMEOUT_CYCLES, 65535, maximum cycles a phase may run before abort (min 2)
TO_W, 16, width of timeout counter
CNT_W, 8, width of pass/fail counters

Ports:
clk_40_m  in  1  system clock
rst  in  1  reset (see Behaviour)
start  in  1  level; begin a campaign (sign_on)
abort  in  1  level; stop the campaign immediately
en_rx  in  1  enable RX phase
en_tx  in  1  enable TX phase
en_adv  in  1  enable custom-message phase
bus_mask  in  N_BUSES  1 = bus included in the campaign
rx_end  in  1  pulse; RX phase finished (data generator)
tx_end  in  1  pulse; TX phase finished
adv_end  in  1  pulse; custom-message phase finished
phase_pass  in  1  result qualifier; sampled in the same cycle as *_end
test_rx  out  1  RX phase request level
test_tx  out  1  TX phase request level
test_adv  out  1  custom-message request level
endwait_all  out  1  one-cycle pulse after each RX phase
bus_sel  out  BUS_W  index of the bus under test
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign completion
pass_cnt  out  CNT_W  phases passed, saturating
fail_cnt  out  CNT_W  phases failed or timed out, saturating
timeout_flag  out  1  sticky; at least one phase timed out
timeout_bus  out  BUS_W  bus index of the most recent timeout

Behaviour:
- Reset is rst, synchronous, active-low; the clock is clk_40_m. While rst=0, all outputs are 0, the state is IDLE, and all counters are 0.
- States: IDLE, RX_RUN, ENDWAIT, GAP, TX_RUN, ADV_RUN, NEXT_BUS, DONE.
- IDLE: when start=1 and abort=0, the sequencer accepts the campaign.
  - At edge k+1 after acceptance: busy=1; pass_cnt, fail_cnt, timeout_flag and timeout_bus clear to 0.
  - bus_sel is loaded with the lowest set bit of bus_mask.
  - The state becomes the first enabled phase, in the order RX, TX, ADV.
  - If bus_mask=0 or no phase is enabled, the state goes directly to DONE.
- start is ignored while busy=1. start held high after DONE re-arms only after one IDLE cycle.
- *_RUN states: the matching test_* output is 1 for the whole state. Only one test_* output is high at any time.
  - The timeout counter clears on entry and increments every cycle.
- Phase completion: the matching *_end is sampled at 1.
  - phase_pass=1 increments pass_cnt; otherwise fail_cnt increments.
  - test_* goes to 0 on the next edge.
  - End pulses that do not belong to the current phase are ignored (no count).
- Timeout: the counter reaches TIMEOUT_CYCLES-1 with no end pulse.
  - fail_cnt increments, timeout_flag sets, timeout_bus is set to bus_sel, and the phase is left as if it had ended.
  - An end pulse in the same cycle as expiry takes priority: no timeout is recorded.
- After RX_RUN, the state is ENDWAIT: endwait_all=1 for exactly one cycle.
  - If en_tx=1, ENDWAIT is followed by GAP for exactly GAP_CYCLES cycles with all test_* at 0, then TX_RUN.
  - If en_tx=0, ENDWAIT goes to ADV_RUN when en_adv=1, else to NEXT_BUS.
- TX_RUN goes to ADV_RUN when en_adv=1, else to NEXT_BUS.
- en_* and bus_mask are sampled only at acceptance; they are held internally for the whole campaign.
- NEXT_BUS takes one cycle.
  - bus_sel moves to the next higher set mask bit, found by a combinational priority search.
  - If no higher set bit exists, the state goes to DONE.
- DONE takes one cycle: done=1 and busy goes to 0 on the following edge; then IDLE.
  - Counters and flags hold their values until the next acceptance.
- Counters saturate at all-ones and do not wrap.
- abort=1 in any busy state: on the next edge, all test_* and endwait_all go to 0, busy goes to 0, and the state returns to IDLE.
  - done is not pulsed. Counters hold their values.
  - abort has priority over end pulses and timeout in the same cycle.
- Reset mid-campaign behaves identically to reset from IDLE.

Test Plan:
1. N_BUSES=32, mask=32'h0000_0011, en_rx=en_tx=1, generator answers rx_end/tx_end with phase_pass=1 after 50 cycles -> bus_sel sequence is 0 then 4; endwait_all pulses twice; test_tx rises exactly GAP_CYCLES+1 cycles after each endwait_all; pass_cnt=4, fail_cnt=0; one done pulse.
2. TIMEOUT_CYCLES=200, mask=1<<7, en_rx=1, no rx_end -> test_rx falls after 200 cycles; fail_cnt=1, timeout_flag=1, timeout_bus=7; done pulses.
3. rx_end pulse with phase_pass=0 on bus 3, plus a stray tx_end during RX_RUN -> fail_cnt=1; the stray pulse is not counted; test_tx stays 0 until GAP completes.
4. abort=1 during the GAP state of bus 2 -> all outputs except the counters and flags are 0 after one edge; no done pulse; a new start restarts with counters cleared.
5. bus_mask=0, start=1 -> busy high for one cycle, done pulse, no test_* or endwait_all activity, counters remain 0.
6. 300 passing phases with CNT_W=8 -> pass_cnt saturates at 255; rst=0 mid-campaign -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/mopshub_test_sequencer.sv
`default_nettype none
// ============================================================================
// mopshub_test_sequencer : per-bus RX / TX / custom-message bring-up campaign
// Revision: 1.0
// ============================================================================
module mopshub_test_sequencer #(
    parameter int N_BUSES        = 32,
    parameter int BUS_W          = 5,
    parameter int GAP_CYCLES     = 120,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16,
    parameter int CNT_W          = 8
) (
    input  logic               clk_40_m,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               en_rx,
    input  logic               en_tx,
    input  logic               en_adv,
    input  logic [N_BUSES-1:0] bus_mask,
    input  logic               rx_end,
    input  logic               tx_end,
    input  logic               adv_end,
    input  logic               phase_pass,
    output logic               test_rx,
    output logic               test_tx,
    output logic               test_adv,
    output logic               endwait_all,
    output logic [BUS_W-1:0]   bus_sel,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               timeout_flag,
    output logic [BUS_W-1:0]   timeout_bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_RUN, S_ENDWAIT, S_GAP, S_TX_RUN, S_ADV_RUN, S_NEXT_BUS, S_DONE
    } state_t;

    // One counter serves both the phase timeout and the inter-phase gap.
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   bus_sel_q, bus_sel_d;
    logic [N_BUSES-1:0] mask_q, mask_d;
    logic               en_rx_q, en_rx_d, en_tx_q, en_tx_d, en_adv_q, en_adv_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
    logic               to_flag_q, to_flag_d;
    logic [BUS_W-1:0]   to_bus_q, to_bus_d;

    logic               first_found, nxt_found;
    logic [BUS_W-1:0]   first_idx, nxt_idx;
    logic               in_run, run_end;
    state_t             after_run;

    function automatic state_t first_phase(input logic r, input logic t);
        if (r)      return S_RX_RUN;
        else if (t) return S_TX_RUN;
        else        return S_ADV_RUN;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Descending loops so the lowest qualifying index wins.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int i = N_BUSES - 1; i >= 0; i--) begin
            if (bus_mask[i]) begin
                first_found = 1'b1;
                first_idx   = BUS_W'(i);
            end
            if (mask_q[i] && (i > int'(bus_sel_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = BUS_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_sel_d = bus_sel_q;
        mask_d    = mask_q;
        en_rx_d   = en_rx_q;
        en_tx_d   = en_tx_q;
        en_adv_d  = en_adv_q;
        cnt_d     = '0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        to_flag_d = to_flag_q;
        to_bus_d  = to_bus_q;
        in_run    = 1'b0;
        run_end   = 1'b0;
        after_run = S_NEXT_BUS;

        case (state_q)
            S_IDLE: begin
                bus_sel_d = '0;
                if (start && !abort) begin
                    mask_d    = bus_mask;
                    en_rx_d   = en_rx;
                    en_tx_d   = en_tx;
                    en_adv_d  = en_adv;
                    pass_d    = '0;
                    fail_d    = '0;
                    to_flag_d = 1'b0;
                    to_bus_d  = '0;
                    bus_sel_d = first_idx;
                    if (!first_found || !(en_rx || en_tx || en_adv))
                        state_d = S_DONE;
                    else
                        state_d = first_phase(en_rx, en_tx);
                end
            end
            S_RX_RUN: begin
                in_run    = 1'b1;
                run_end   = rx_end;
                after_run = S_ENDWAIT;
            end
            S_TX_RUN: begin
                in_run    = 1'b1;
                run_end   = tx_end;
                after_run = en_adv_q ? S_ADV_RUN : S_NEXT_BUS;
            end
            S_ADV_RUN: begin
                in_run  = 1'b1;
                run_end = adv_end;
            end
            S_ENDWAIT: begin
                if (en_tx_q)       state_d = S_GAP;
                else if (en_adv_q) state_d = S_ADV_RUN;
                else               state_d = S_NEXT_BUS;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_TX_RUN;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_NEXT_BUS: begin
                if (nxt_found) begin
                    bus_sel_d = nxt_idx;
                    state_d   = first_phase(en_rx_q, en_tx_q);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus_sel_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An end pulse in the expiry cycle is a normal completion, not a timeout.
        if (in_run) begin
            if (run_end || (cnt_q == TO_LAST)) begin
                state_d = after_run;
                if (run_end && phase_pass) pass_d = sat_inc(pass_q);
                else                       fail_d = sat_inc(fail_q);
                if (!run_end) begin
                    to_flag_d = 1'b1;
                    to_bus_d  = bus_sel_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            bus_sel_d = '0;
            cnt_d     = '0;
            pass_d    = pass_q;
            fail_d    = fail_q;
            to_flag_d = to_flag_q;
            to_bus_d  = to_bus_q;
        end
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bus_sel_q <= '0;
            mask_q    <= '0;
            en_rx_q   <= 1'b0;
            en_tx_q   <= 1'b0;
            en_adv_q  <= 1'b0;
            cnt_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            to_flag_q <= 1'b0;
            to_bus_q  <= '0;
        end else begin
            state_q   <= state_d;
            bus_sel_q <= bus_sel_d;
            mask_q    <= mask_d;
            en_rx_q   <= en_rx_d;
            en_tx_q   <= en_tx_d;
            en_adv_q  <= en_adv_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            to_flag_q <= to_flag_d;
            to_bus_q  <= to_bus_d;
        end
    end

    assign test_rx      = (state_q == S_RX_RUN);
    assign test_tx      = (state_q == S_TX_RUN);
    assign test_adv     = (state_q == S_ADV_RUN);
    assign endwait_all  = (state_q == S_ENDWAIT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign bus_sel      = bus_sel_q;
    assign pass_cnt     = pass_q;
    assign fail_cnt     = fail_q;
    assign timeout_flag = to_flag_q;
    assign timeout_bus  = to_bus_q;

endmodule
`default_nettype wire
